// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB first,
// repeated N passes with optional idle gaps, with start/busy/done handshake.
module sequence_generator #(
    parameter int WIDTH      = 8,
    parameter int REPEAT_W   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [REPEAT_W-1:0]        repeat_count,
    output logic                       w,
    output logic                       w_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_index,
    output logic [1:0]                 state
);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                st_q, st_n;
    logic [IW-1:0]         idx_q, idx_n;
    logic [WIDTH-1:0]      pat_q, pat_n;
    logic [REPEAT_W-1:0]   pass_q, pass_n;
    logic [GW-1:0]         gap_q, gap_n;
    logic                  w_q, w_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            idx_q  <= '0;
            pat_q  <= '0;
            pass_q <= '0;
            gap_q  <= '0;
            w_q    <= 1'b0;
        end else begin
            st_q   <= st_n;
            idx_q  <= idx_n;
            pat_q  <= pat_n;
            pass_q <= pass_n;
            gap_q  <= gap_n;
            w_q    <= w_n;
        end
    end

    // w is computed one cycle ahead so it leaves a flop alongside the state change
    always_comb begin
        st_n   = st_q;
        idx_n  = idx_q;
        pat_n  = pat_q;
        pass_n = pass_q;
        gap_n  = gap_q;
        w_n    = 1'b0;
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_n   = SHIFT;
                    pat_n  = pattern;
                    pass_n = (repeat_count == '0) ? REPEAT_W'(1) : repeat_count;
                    idx_n  = IDX_MSB;
                    w_n    = pattern[WIDTH-1];
                end
            end
            SHIFT: begin
                if (idx_q != '0) begin
                    idx_n = idx_q - 1'b1;
                    w_n   = pat_q[idx_n];
                end else if (pass_q > REPEAT_W'(1)) begin
                    pass_n = pass_q - 1'b1;
                    if (GAP_CYCLES == 0) begin
                        idx_n = IDX_MSB;
                        w_n   = pat_q[WIDTH-1];
                    end else begin
                        st_n  = GAP;
                        gap_n = GAP_LAST;
                    end
                end else begin
                    st_n = DONE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    st_n  = SHIFT;
                    idx_n = IDX_MSB;
                    w_n   = pat_q[WIDTH-1];
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            DONE: st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    assign w         = w_q;
    assign w_valid   = (st_q == SHIFT);
    assign busy      = (st_q == SHIFT) || (st_q == GAP);
    assign done      = (st_q == DONE);
    assign bit_index = idx_q;
    assign state     = st_q;
endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench: one instance with a 2-cycle inter-pass gap, one with none.
module tb_sequence_generator;
    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] pattern;
    logic [3:0] repeat_count;

    logic       a_w, a_v, a_busy, a_done, b_w, b_v, b_busy, b_done;
    logic [2:0] a_idx, b_idx;
    logic [1:0] a_st, b_st;

    logic       sel;
    logic       o_w, o_v, o_busy, o_done;
    logic [2:0] o_idx;
    logic [1:0] o_st;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(8), .REPEAT_W(4), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .reset(reset), .start(start_a), .pattern(pattern),
        .repeat_count(repeat_count), .w(a_w), .w_valid(a_v), .busy(a_busy),
        .done(a_done), .bit_index(a_idx), .state(a_st)
    );

    sequence_generator #(.WIDTH(8), .REPEAT_W(4), .GAP_CYCLES(0)) u_nogap (
        .clk(clk), .reset(reset), .start(start_b), .pattern(pattern),
        .repeat_count(repeat_count), .w(b_w), .w_valid(b_v), .busy(b_busy),
        .done(b_done), .bit_index(b_idx), .state(b_st)
    );

    assign o_w    = sel ? b_w    : a_w;
    assign o_v    = sel ? b_v    : a_v;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_idx  = sel ? b_idx  : a_idx;
    assign o_st   = sel ? b_st   : a_st;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 32'(o_st), 0);
        chk({tag, ".w"}, 32'(o_w), 0);
        chk({tag, ".w_valid"}, 32'(o_v), 0);
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".done"}, 32'(o_done), 0);
    endtask

    task automatic go(input logic s, input logic [7:0] pat, input logic [3:0] rep);
        sel = s;
        pattern = pat;
        repeat_count = rep;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Entered on the first bit cycle; leaves on the IDLE cycle after done.
    task automatic expect_stream(input string tag, input logic [7:0] pat, input int npass, input int gap);
        int busy_cycles = 0;
        for (int p = 0; p < npass; p++) begin
            for (int i = 7; i >= 0; i--) begin
                chk({tag, ".w"}, 32'(o_w), 32'(pat[i]));
                chk({tag, ".w_valid"}, 32'(o_v), 1);
                chk({tag, ".bit_index"}, 32'(o_idx), 32'(i));
                chk({tag, ".busy"}, 32'(o_busy), 1);
                busy_cycles++;
                step();
            end
            if (p < npass - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk({tag, ".gap_w"}, 32'(o_w), 0);
                    chk({tag, ".gap_valid"}, 32'(o_v), 0);
                    chk({tag, ".gap_state"}, 32'(o_st), 2);
                    chk({tag, ".gap_busy"}, 32'(o_busy), 1);
                    busy_cycles++;
                    step();
                end
            end
        end
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(npass * 8 + (npass - 1) * gap));
        chk({tag, ".done"}, 32'(o_done), 1);
        chk({tag, ".done_state"}, 32'(o_st), 3);
        chk({tag, ".done_busy"}, 32'(o_busy), 0);
        chk({tag, ".done_w"}, 32'(o_w), 0);
        chk({tag, ".done_valid"}, 32'(o_v), 0);
        step();
        chk({tag, ".after_state"}, 32'(o_st), 0);
        chk({tag, ".after_done"}, 32'(o_done), 0);
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        pattern = 8'h00;
        repeat_count = 4'd0;
        sel = 1'b0;
        step();
        step();
        sel = 1'b0; chk_idle("rst_a"); chk("rst_a.idx", 32'(o_idx), 0);
        sel = 1'b1; chk_idle("rst_b"); chk("rst_b.idx", 32'(o_idx), 0);
        reset = 1'b0;
        step();

        // 1: single pass of 1011_0010
        go(1'b0, 8'b1011_0010, 4'd1);
        expect_stream("t1", 8'b1011_0010, 1, 0);

        // 2: A5 x3 with 2-cycle gaps
        go(1'b0, 8'hA5, 4'd3);
        expect_stream("t2", 8'hA5, 3, 2);

        // 3: repeat 0 behaves as 1
        go(1'b0, 8'h6C, 4'd0);
        expect_stream("t3", 8'h6C, 1, 0);

        // 4: FF x2 back to back, bit_index wraps 0 -> 7
        go(1'b1, 8'hFF, 4'd2);
        expect_stream("t4", 8'hFF, 2, 0);

        // 5: start with a new pattern mid-stream is ignored
        go(1'b0, 8'h0F, 4'd1);
        for (int i = 7; i >= 0; i--) begin
            chk("t5.w", 32'(a_w), 32'((i < 4) ? 1 : 0));
            chk("t5.idx", 32'(a_idx), 32'(i));
            if (i == 4) begin
                start_a = 1'b1;
                pattern = 8'hF0;
            end
            step();
            start_a = 1'b0;
        end
        chk("t5.done", 32'(a_done), 1);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t5.no_second_done", 32'(a_done), 0);
            chk("t5.stay_idle", 32'(a_st), 0);
            step();
        end

        // 6: reset at bit_index 3, then a fresh transmission
        go(1'b0, 8'hC3, 4'd2);
        step(); step(); step(); step();
        chk("t6.at_idx3", 32'(a_idx), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("t6.after_reset");
        chk("t6.idx", 32'(a_idx), 0);
        go(1'b0, 8'h81, 4'd1);
        expect_stream("t6.fresh", 8'h81, 1, 0);

        // reset and start together: reset wins
        reset = 1'b1;
        start_a = 1'b1;
        pattern = 8'hFF;
        step();
        reset = 1'b0;
        start_a = 1'b0;
        chk_idle("rs_same");

        // max repeat count is fully honoured
        go(1'b0, 8'h5A, 4'd15);
        expect_stream("max_rep", 8'h5A, 15, 2);

        // start held through DONE -> IDLE; pattern changes while busy are ignored
        sel = 1'b1;
        pattern = 8'h3C;
        repeat_count = 4'd1;
        start_b = 1'b1;
        step();
        pattern = 8'h80;
        expect_stream("held", 8'h3C, 1, 0);
        step();
        chk("held.restart_state", 32'(b_st), 1);
        chk("held.restart_w", 32'(b_w), 1);
        chk("held.restart_idx", 32'(b_idx), 7);
        start_b = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("final");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
